// File: rtl/token_plotter.sv
// Connect Four token drawer: expands one cell request into a per-pixel (x, y, colour) beat stream
// for the VGA adapter, with ready back-pressure and a whole-board clear sweep.
module token_plotter #(
    parameter int GRID_LEN  = 2,
    parameter int BLOCK_LEN = 4,
    parameter int COLS      = 7,
    parameter int ROWS      = 6,
    parameter int PREVIEW_Y = 128,
    parameter int X_W       = 9,
    parameter int Y_W       = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [2:0]     col,
    input  logic [2:0]     row,
    input  logic           player,
    input  logic [1:0]     mode,
    input  logic           ready,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int PXW   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int PITCH = GRID_LEN + BLOCK_LEN;

    localparam logic [1:0] MODE_PLACE   = 2'b00;
    localparam logic [1:0] MODE_PREVIEW = 2'b01;
    localparam logic [1:0] MODE_ERASE   = 2'b10;
    localparam logic [1:0] MODE_CLEAR   = 2'b11;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    function automatic logic [X_W-1:0] calc_x(input logic [2:0] c, input logic [PXW-1:0] p);
        int v;
        v = GRID_LEN + int'(c) * PITCH + int'(p);
        return v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] calc_y(input logic [1:0] m, input logic [2:0] r,
                                              input logic [PXW-1:0] p);
        int v;
        if (m == MODE_PREVIEW)
            v = PREVIEW_Y + int'(p);
        else
            v = GRID_LEN + int'(r) * PITCH + int'(p);
        return v[Y_W-1:0];
    endfunction

    // Place/preview paint the player's colour; erase/clear paint background.
    function automatic logic [2:0] calc_colour(input logic [1:0] m, input logic pl);
        return m[1] ? 3'b000 : {1'b1, pl, 1'b0};
    endfunction

    state_t         state_reg, state_next;
    logic [PXW-1:0] px_reg, px_next;
    logic [PXW-1:0] py_reg, py_next;
    logic [2:0]     cc_reg, cc_next;
    logic [2:0]     rr_reg, rr_next;
    logic [1:0]     mode_reg, mode_next;
    logic           player_reg, player_next;
    logic [X_W-1:0] x_reg, x_next;
    logic [Y_W-1:0] y_reg, y_next;
    logic [2:0]     colour_reg, colour_next;
    logic           plot_reg, plot_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic           err_reg, err_next;

    logic last_px, last_py, last_cell, col_bad, row_bad;

    assign last_px   = (px_reg == PXW'(BLOCK_LEN - 1));
    assign last_py   = (py_reg == PXW'(BLOCK_LEN - 1));
    assign last_cell = (mode_reg != MODE_CLEAR) ||
                       ((cc_reg == 3'(COLS - 1)) && (rr_reg == 3'(ROWS - 1)));
    assign col_bad   = (mode != MODE_CLEAR) && (int'(col) >= COLS);
    assign row_bad   = ((mode == MODE_PLACE) || (mode == MODE_ERASE)) && (int'(row) >= ROWS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            px_reg     <= '0;
            py_reg     <= '0;
            cc_reg     <= '0;
            rr_reg     <= '0;
            mode_reg   <= '0;
            player_reg <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            px_reg     <= px_next;
            py_reg     <= py_next;
            cc_reg     <= cc_next;
            rr_reg     <= rr_next;
            mode_reg   <= mode_next;
            player_reg <= player_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        px_next     = px_reg;
        py_next     = py_reg;
        cc_next     = cc_reg;
        rr_next     = rr_reg;
        mode_next   = mode_reg;
        player_next = player_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        plot_next   = plot_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                plot_next = 1'b0;
                busy_next = 1'b0;
                if (start) begin
                    if (col_bad || row_bad) begin
                        err_next = 1'b1;
                    end else begin
                        // Single-cell modes park the cell counters on the target cell;
                        // clear sweeps them from cell (0,0).
                        state_next  = DRAW;
                        mode_next   = mode;
                        player_next = player;
                        px_next     = '0;
                        py_next     = '0;
                        cc_next     = (mode == MODE_CLEAR) ? 3'd0 : col;
                        rr_next     = (mode == MODE_CLEAR) ? 3'd0 : row;
                        x_next      = calc_x(cc_next, '0);
                        y_next      = calc_y(mode, rr_next, '0);
                        colour_next = calc_colour(mode, player);
                        plot_next   = 1'b1;
                        busy_next   = 1'b1;
                    end
                end
            end

            DRAW: begin
                if (ready) begin
                    if (last_px && last_py && last_cell) begin
                        state_next = DONE;
                        plot_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        if (!last_px) begin
                            px_next = px_reg + PXW'(1);
                        end else begin
                            px_next = '0;
                            if (!last_py) begin
                                py_next = py_reg + PXW'(1);
                            end else begin
                                py_next = '0;
                                if (cc_reg == 3'(COLS - 1)) begin
                                    cc_next = 3'd0;
                                    rr_next = rr_reg + 3'd1;
                                end else begin
                                    cc_next = cc_reg + 3'd1;
                                end
                            end
                        end
                        x_next = calc_x(cc_next, px_next);
                        y_next = calc_y(mode_reg, rr_next, py_next);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                plot_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign x_out  = x_reg;
    assign y_out  = y_reg;
    assign colour = colour_reg;
    assign plot   = plot_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_token_plotter.sv
// Directed bench for token_plotter: expected beats are queued per request and popped as the DUT
// transfers them; busy length, done pulses, err, hold under back-pressure and reset abort are checked.
module tb_token_plotter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] col;
    logic [2:0] row;
    logic       player;
    logic [1:0] mode;
    logic       ready;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       err;

    token_plotter dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .col    (col),
        .row    (row),
        .player (player),
        .mode   (mode),
        .ready  (ready),
        .x_out  (x_out),
        .y_out  (y_out),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    logic [19:0] sb_q[$];
    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vecs++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference geometry for the default parameters: pitch 6, gap 2, preview strip at y=128.
    task automatic push_cell(input logic [1:0] m, input int c, input int r, input logic p);
        logic [8:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        for (int py = 0; py < 4; py++) begin
            for (int px = 0; px < 4; px++) begin
                ex = 9'(2 + c * 6 + px);
                ey = (m == 2'b01) ? 8'(128 + py) : 8'(2 + r * 6 + py);
                ec = m[1] ? 3'b000 : {1'b1, p, 1'b0};
                sb_q.push_back({ex, ey, ec});
            end
        end
    endtask

    task automatic run_req(input logic [1:0] m, input logic [2:0] c, input logic [2:0] r,
                           input logic p, input int lo, input int len, input int bump,
                           input int abort_at, input int exp_busy);
        int k, xfers, busy_cnt, done_cnt;
        logic [19:0] e;
        mode = m; col = c; row = r; player = p; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; xfers = 0; busy_cnt = 0; done_cnt = 0;
        while (k < 2000) begin
            ready = !(k >= lo && k < lo + len);
            start = (k == bump);
            if (k == bump) begin
                mode = 2'b00; col = 3'd1; row = 3'd0;
            end
            if (k == 0) chk("first_plot", 32'(plot), 1);
            if (abort_at >= 0 && xfers == abort_at) begin
                resetn = 1'b0;
                #1;
                chk("abort_outputs", 32'({x_out, y_out, colour, plot, busy, done, err}), 0);
                break;
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (plot) begin
                if (sb_q.size() == 0) begin
                    chk("extra_beat", 32'(plot), 0);
                end else begin
                    e = ready ? sb_q.pop_front() : sb_q[0];
                    chk($sformatf("beat%0d", xfers), 32'({x_out, y_out, colour}), 32'(e));
                    if (ready) xfers++;
                end
            end
            if (!busy && k > 0) break;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        ready = 1'b1;
        if (k >= 2000) chk("timeout", 32'(k), 0);
        if (abort_at < 0) begin
            chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
            chk("done_pulses", 32'(done_cnt), 1);
            chk("queue_drained", 32'(sb_q.size()), 0);
            $display("request mode=%0d col=%0d row=%0d player=%0d: %0d transfers, busy %0d cycles",
                     m, c, r, p, xfers, busy_cnt);
        end else begin
            chk("abort_no_done", 32'(done_cnt), 0);
            $display("request mode=%0d col=%0d row=%0d aborted after %0d transfers", m, c, r, xfers);
        end
    endtask

    task automatic err_req(input logic [1:0] m, input logic [2:0] c, input logic [2:0] r);
        mode = m; col = c; row = r; player = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", 32'(err), 1);
        chk("err_busy_plot", 32'({busy, plot}), 0);
        @(posedge clk); #1;
        chk("err_one_cycle", 32'({err, busy, plot}), 0);
        $display("rejected request mode=%0d col=%0d row=%0d", m, c, r);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; ready = 1'b1;
        mode = 2'b00; col = 3'd0; row = 3'd0; player = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({x_out, y_out, colour, plot, busy, done, err}), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        push_cell(2'b00, 0, 0, 1'b1);
        run_req(2'b00, 3'd0, 3'd0, 1'b1, -1, 0, -1, -1, 17);

        push_cell(2'b00, 6, 5, 1'b0);
        run_req(2'b00, 3'd6, 3'd5, 1'b0, -1, 0, -1, -1, 17);

        // Preview ignores row, so an out-of-range row must still be accepted.
        push_cell(2'b01, 3, 0, 1'b1);
        run_req(2'b01, 3'd3, 3'd7, 1'b1, 6, 3, -1, -1, 20);

        err_req(2'b00, 3'd7, 3'd0);
        err_req(2'b10, 3'd0, 3'd6);

        push_cell(2'b10, 2, 3, 1'b1);
        run_req(2'b10, 3'd2, 3'd3, 1'b1, -1, 0, 5, -1, 17);
        @(posedge clk); #1;
        chk("busy_start_ignored", 32'({busy, plot}), 0);

        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                push_cell(2'b11, c, r, 1'b0);
        run_req(2'b11, 3'd7, 3'd7, 1'b1, -1, 0, -1, -1, 673);

        push_cell(2'b00, 1, 1, 1'b0);
        run_req(2'b00, 3'd1, 3'd1, 1'b0, -1, 0, -1, 5, 17);
        repeat (3) @(posedge clk);
        #1;
        chk("held_in_reset", 32'({x_out, y_out, colour, plot, busy, done, err}), 0);
        sb_q.delete();
        resetn = 1'b1;
        @(posedge clk); #1;

        push_cell(2'b00, 4, 2, 1'b1);
        run_req(2'b00, 3'd4, 3'd2, 1'b1, -1, 0, -1, -1, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/token_plotter.md
# token_plotter

Parametrised Connect Four token drawer between game control and the VGA adapter. Given one request (column, row, player, mode) it walks every pixel of a BLOCK_LEN×BLOCK_LEN token cell itself and emits one (x, y, colour, plot) beat per pixel. Modes cover placing a token, drawing the drop preview, erasing a cell and clearing the whole board. A ready input gives the adapter back-pressure.

## Interface
- GRID_LEN, 2: gap in pixels before each cell, horizontal and vertical
- BLOCK_LEN, 4: cell side in pixels; power of two, 2..16
- COLS, 7: board columns
- ROWS, 6: board rows; row 0 is the top row
- PREVIEW_Y, 128: top y of the preview strip
- X_W, 9: width of x_out
- Y_W, 8: width of y_out
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  request strobe; accepted only when busy=0
- col  in  3  target column, 0..COLS-1
- row  in  3  target row, 0..ROWS-1; ignored in preview and clear modes
- player  in  1  owning player, 0 or 1
- mode  in  2  00 place, 01 preview, 10 erase, 11 clear board
- ready  in  1  adapter accepts the current beat
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour  out  3  pixel colour
- plot  out  1  beat valid
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejection pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE with start=1: latch col, row, player and mode.
  - Range check applies to col in all modes except clear, and to row in place and erase modes.
  - Out of range: pulse err, stay IDLE, no plot.
  - Otherwise go to DRAW, with pixel counters and cell counters at 0.
- DRAW: present one beat with plot=1.
  - A beat transfers when plot&ready.
  - On transfer, the pixel counter advances: px runs 0..BLOCK_LEN-1 fastest, then py.
  - On plot&!ready, x_out, y_out and colour hold stable.
- Coordinates:
  - x = GRID_LEN + c*(GRID_LEN+BLOCK_LEN) + px
  - Place and erase: y = GRID_LEN + r*(GRID_LEN+BLOCK_LEN) + py
  - Preview: y = PREVIEW_Y + py
  - Results are truncated to X_W and Y_W bits.
- Colour: place and preview use {1, player, 0}; erase and clear use 000.
- Clear mode iterates every cell in cell-major order: c runs 0..COLS-1 fastest, then r 0..ROWS-1. Each cell is a full pixel walk.
- After the last transfer, go to DONE. DONE pulses done=1 for one cycle, then returns to IDLE.
- start while busy=1 is ignored, with no err.
- Asynchronous reset clears state to IDLE and all outputs to 0, including mid-request. The aborted request produces no done.

## Timing
- Reset values: x_out=0, y_out=0, colour=0, plot=0, busy=0, done=0, err=0.
- All outputs are registered.
- Start accepted at edge E0. busy and plot rise after E0, and the first beat is valid in the cycle after E0.
- With ready held high, consecutive cycles carry consecutive pixels:
  - Single cell: BLOCK_LEN² beats.
  - Clear: COLS·ROWS·BLOCK_LEN² beats.
- plot falls and done pulses in the cycle after the last transfer. busy stays high through the done cycle and drops the cycle after.
- The earliest next start is accepted in the cycle busy=0. Throughput is one beat per cycle.
- err pulses in the cycle after the rejecting edge. busy stays 0.

## Test plan
- Place, col=0, row=0, player=1, ready=1: 16 beats with x 2..5 and y 2..5 (x fastest), colour 110, then one done pulse.
- Place, col=6, row=5, player=0: x 38..41, y 32..35, colour 100; busy high for exactly 17 cycles.
- Preview, col=3, player=1: x 20..23, y 128..131, colour 110. Toggle ready low for 3 cycles mid-walk: beats hold, no pixel is skipped or duplicated, and there are still exactly 16 transfers.
- Start with col=7 (place mode), and separately row=6 (erase mode): one err pulse each, no plot, busy stays 0. A start while busy is ignored.
- Clear: 672 beats with colour 000. First beat (2,2), last beat (41,35), then done.
- Assert resetn low at beat 5 of a place request: all outputs 0 asynchronously, no done. A new request after release draws all 16 pixels correctly.
